zap_multi_rank_sync_filter: RTL
===============================

// Module: zap_multi_rank_sync_filter
// PURPOSE
//  Parametrised synchroniser for asynchronous level inputs such as IRQ/FIQ
//  lines, external status pins and cross-domain flags.
//  - N-rank synchroniser chain per bit.
//  - Per-bit glitch filter: a new level must be stable for FILTER cycles.
//  - Registered single-cycle rise/fall pulses per bit.
//  Sits at the core/SoC boundary in front of interrupt and status logic.
// PARAMETERS
//  WIDTH      32'd1   number of independent channels (bits)
//  STAGES     32'd2   synchroniser ranks; minimum 2
//  FILTER     32'd1   consecutive cycles a new level must persist; 1 = no filtering
//  RESET_VAL  '0      [WIDTH-1:0] reset level of every chain flop and o_sync
// PORTS
//  i_clk      in   1      clock
//  i_reset    in   1      synchronous reset, active high
//  i_async    in   WIDTH  asynchronous inputs
//  o_sync     out  WIDTH  synchronised, filtered level
//  o_rise     out  WIDTH  1-cycle pulse: o_sync[i] went 0->1
//  o_fall     out  WIDTH  1-cycle pulse: o_sync[i] went 1->0
//  o_change   out  1      |(o_rise | o_fall)
// BEHAVIOUR
//  - One clock (i_clk). Reset is synchronous and active-high on i_reset.
//    All flops use posedge i_clk only.
//  - Reset values:
//    - Chain flops: RESET_VAL.
//    - o_sync: RESET_VAL.
//    - Counters: 0.
//    - o_rise, o_fall, o_change: 0.
//  - Chain: stage0 <= i_async; stage(k) <= stage(k-1). s = stage(STAGES-1).
//  - Filter, per bit i, with counter cnt[i] of width max(1,$clog2(FILTER)):
//    - s[i] == o_sync[i]: cnt[i] <= 0.
//    - s[i] != o_sync[i] and cnt[i] == FILTER-1: o_sync[i] <= s[i], cnt[i] <= 0.
//    - s[i] != o_sync[i] otherwise: cnt[i] <= cnt[i]+1. cnt never exceeds FILTER-1.
//  - Latency: i_async stable before sampling edge k; o_sync shows the new value
//    after edge k+STAGES-1+FILTER. Example: STAGES=2, FILTER=1 gives 3 edges.
//  - Edge pulses:
//    - On the edge where o_sync[i] is updated 0->1, o_rise[i] <= 1.
//    - On the edge where o_sync[i] is updated 1->0, o_fall[i] <= 1.
//    - Otherwise both <= 0.
//    - Pulses are coincident with the first cycle of the new o_sync value.
//    - Pulses are exactly 1 cycle wide.
//    - o_change is registered and coincident with the pulses.
//  - Glitch: if a mismatch vanishes before the count completes, the counter
//    clears, o_sync holds and no pulse is produced.
//  - Re-toggle: with FILTER=1, alternating rise/fall on consecutive cycles is legal.
//  - Reset mid-operation: reset clears chain, count and pulses in the same edge.
//    - After release, a full STAGES-1+FILTER qualification restarts.
//    - No pulse is emitted by reset itself. A pulse is emitted only when a
//      qualified level differing from RESET_VAL is reached.
//  - Channels are fully independent; simultaneous events on several bits are
//    all reported in the same cycle.
//  - Elaboration $error if STAGES < 2, FILTER < 1 or WIDTH < 1.
//  - No combinational path from inputs to outputs.
// STRUCTURE
//  - zap_sync_pkg: ZAP_SYNC_MIN_STAGES = 2, ZAP_SYNC_MIN_FILTER = 1, and a
//    function cnt_width(FILTER) returning max(1,$clog2(FILTER)).
//  - Top: chain as [STAGES-1:0][WIDTH-1:0] flop array, plus a generate loop of
//    WIDTH instances of sub-module zap_sync_filter_bit.
//  - zap_sync_filter_bit holds counter, o_sync bit, rise/fall flops.
//  - o_change reduction and register live in the top.
// TESTING  (WIDTH=4, STAGES=3, FILTER=4, RESET_VAL=4'h0 unless stated)
//  1. i_async=4'hF held through 2 reset cycles:
//     -> outputs 0 during reset; o_sync=4'hF exactly 6 edges after first
//        post-reset sampling edge; o_rise=4'hF and o_change=1 for 1 cycle.
//  2. bit0 high for 3 cycles, then low:
//     -> o_sync stays 4'h0, no pulse.
//     Repeat with bit0 high for 4 cycles:
//     -> o_sync[0]=1, o_rise=4'h1 for 1 cycle.
//  3. From o_sync=4'hF, drive i_async=4'h0:
//     -> o_sync=4'h0 after 6 edges, o_fall=4'hF for 1 cycle, o_rise=0.
//  4. bit1 rises at cycle 10, bit2 rises at cycle 12:
//     -> separate o_rise pulses 4'h2 and 4'h4, 2 cycles apart.
//     Both bits rising at the same cycle -> a single o_rise=4'h6 pulse.
//  5. Assert i_reset when cnt[0]=2:
//     -> o_sync=0 and no pulse; after release, a full 6-edge qualification
//        is required.
//  6. FILTER=1, STAGES=2, bit0 toggled every cycle:
//     -> o_sync[0] toggles every cycle at 3-edge latency; o_rise/o_fall alternate.

Source files
------------

// File: rtl/zap_sync_pkg.sv
// Shared constants and helpers for the multi-rank synchroniser/filter.
//   ZAP_SYNC_MIN_STAGES : smallest legal number of synchroniser ranks
//   ZAP_SYNC_MIN_FILTER : smallest legal filter length (1 = pass-through)
//   cnt_width()         : width of the per-bit stability counter
package zap_sync_pkg;

  localparam int unsigned ZAP_SYNC_MIN_STAGES = 32'd2;
  localparam int unsigned ZAP_SYNC_MIN_FILTER = 32'd1;

  // max(1, clog2(filter)); a counter must be at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned filter);
    int unsigned w;
    w = $clog2(filter);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/zap_multi_rank_sync_filter_if.sv
// Bundle of the per-channel level inputs and filtered outputs.
//   i_async  : asynchronous level inputs
//   o_sync   : synchronised, filtered levels
//   o_rise   : 1-cycle pulse per bit on a 0->1 update of o_sync
//   o_fall   : 1-cycle pulse per bit on a 1->0 update of o_sync
//   o_change : OR of all rise/fall pulses
// master drives i_async, slave (the synchroniser) drives the outputs.
interface zap_multi_rank_sync_filter_if #(
  parameter int unsigned WIDTH = 32'd1
);

  logic [WIDTH-1:0] i_async;
  logic [WIDTH-1:0] o_sync;
  logic [WIDTH-1:0] o_rise;
  logic [WIDTH-1:0] o_fall;
  logic             o_change;

  modport master (
    output i_async,
    input  o_sync, o_rise, o_fall, o_change
  );

  modport slave (
    input  i_async,
    output o_sync, o_rise, o_fall, o_change
  );

endinterface

// File: rtl/zap_sync_filter_bit.sv
// Single-channel glitch filter and edge detector.
// A synchronised level that differs from o_sync must persist for FILTER
// consecutive cycles before o_sync adopts it; the update edge also sets a
// registered rise or fall pulse.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_s            : level from the last synchroniser rank
//   o_sync         : filtered level
//   o_rise/o_fall  : registered 1-cycle pulses on o_sync updates
//   o_pulse_nxt    : high when o_sync updates on the coming edge
module zap_sync_filter_bit
  import zap_sync_pkg::*;
#(
  parameter int unsigned FILTER    = 32'd1,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_s,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall,
  output logic o_pulse_nxt
);

  localparam int unsigned    CW       = cnt_width(FILTER);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER - 32'd1);

  logic [CW-1:0] r_cnt;
  logic          r_sync;
  logic          r_rise;
  logic          r_fall;
  logic          w_diff;
  logic          w_done;

  assign w_diff = i_s ^ r_sync;
  assign w_done = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_sync <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_done &  i_s;
      r_fall <= w_done & ~i_s;
      if (w_done) begin
        r_sync <= i_s;
      end
      // Counter restarts on any match (glitch vanished) and after an update.
      if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_sync      = r_sync;
  assign o_rise      = r_rise;
  assign o_fall      = r_fall;
  assign o_pulse_nxt = w_done;

endmodule

// File: rtl/zap_multi_rank_sync_filter.sv
// Multi-rank synchroniser with per-bit glitch filter and edge pulses for
// asynchronous level inputs (IRQ/FIQ lines, status pins, cross-domain flags).
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : i_async in; o_sync, o_rise, o_fall, o_change out
// Every output is a flop; there is no combinational input-to-output path.
module zap_multi_rank_sync_filter
  import zap_sync_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32'd1,
  parameter int unsigned      STAGES    = 32'd2,
  parameter int unsigned      FILTER    = 32'd1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  zap_multi_rank_sync_filter_if.slave  bus
);

  if (STAGES < ZAP_SYNC_MIN_STAGES) begin : g_err_stages
    $error("zap_multi_rank_sync_filter: STAGES must be >= 2");
  end
  if (FILTER < ZAP_SYNC_MIN_FILTER) begin : g_err_filter
    $error("zap_multi_rank_sync_filter: FILTER must be >= 1");
  end
  if (WIDTH < 1) begin : g_err_width
    $error("zap_multi_rank_sync_filter: WIDTH must be >= 1");
  end

  logic [STAGES-1:0][WIDTH-1:0] r_chain;
  logic [WIDTH-1:0]             w_s;
  logic [WIDTH-1:0]             w_sync;
  logic [WIDTH-1:0]             w_rise;
  logic [WIDTH-1:0]             w_fall;
  logic [WIDTH-1:0]             w_pulse_nxt;
  logic                         r_change;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain[0] <= bus.i_async;
      for (int unsigned k = 1; k < STAGES; k++) begin
        r_chain[k] <= r_chain[k-1];
      end
    end
  end

  assign w_s = r_chain[STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    zap_sync_filter_bit #(
      .FILTER    (FILTER),
      .RESET_VAL (RESET_VAL[i])
    ) u_bit (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_s         (w_s[i]),
      .o_sync      (w_sync[i]),
      .o_rise      (w_rise[i]),
      .o_fall      (w_fall[i]),
      .o_pulse_nxt (w_pulse_nxt[i])
    );
  end

  // Registered from the same next-state terms as the per-bit pulse flops so
  // o_change lines up with o_rise/o_fall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_change <= 1'b0;
    end else begin
      r_change <= |w_pulse_nxt;
    end
  end

  assign bus.o_sync   = w_sync;
  assign bus.o_rise   = w_rise;
  assign bus.o_fall   = w_fall;
  assign bus.o_change = r_change;

endmodule
